bus_arb: RTL and testbench
==========================

# bus_arb

Two-master arbiter for the 16 MB word-addressed system bus. It shares the single slave-side bus, which feeds the address decoder and the PROM/RAM/VID/I/O slaves, between master 0 (the CPU) and master 1 (a DMA or bus-master peripheral). Grants are round-robin and held for one complete strobe/acknowledge transaction. An optional watchdog terminates transactions that a slave never acknowledges.

## Interface
Parameters:
- TIMEOUT, 255: max grant cycles without slave ack before forced termination (2..255; watchdog build only).

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous reset, active-low.
- m0_stb  in  1  master 0 request; held high until m0_ack.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  22  master 0 word address [23:2].
- m0_dout  in  32  master 0 write data.
- m0_din  out  32  master 0 read data.
- m0_ack  out  1  master 0 acknowledge.
- m1_stb, m1_we, m1_addr, m1_dout, m1_din, m1_ack: same as m0_*, for master 1.
- bus_stb  out  1  slave-side strobe.
- bus_we  out  1  slave-side write enable.
- bus_addr  out  22  slave-side word address [23:2].
- bus_dout  out  32  slave-side write data.
- bus_din  in  32  slave-side read data.
- bus_ack  in  1  slave-side acknowledge.
- gnt  out  2  one-hot current grant (bit0 = m0, bit1 = m1); 00 when idle.
- err  out  1  sticky timeout flag.
- err_mst  out  1  index of the master whose transaction timed out.
- err_clr  in  1  clears err (single-cycle pulse).

## Operation
- FSM states: IDLE, GNT0, GNT1. State change occurs only at the rising edge of clk.
- In IDLE:
  - Only m0_stb high -> GNT0.
  - Only m1_stb high -> GNT1.
  - Both high -> grant the master not recorded in register last; last updates to the granted master.
  - Neither high -> stay in IDLE.
  - Reset value of last = 1, so m0 wins the first contention.
- In GNTx:
  - bus_stb = mx_stb. bus_we, bus_addr and bus_dout = mx_* (combinational mux).
  - mx_ack = bus_ack and mx_din = bus_din.
  - The other master sees ack = 0 and din = 0.
- Leaving GNTx: bus_ack high, or mx_stb dropping (master abort), -> IDLE. The granted master is never re-granted in the same cycle.
- In IDLE all bus_* outputs are 0, both acks are 0 and both din are 0.
- Write data and read data pass through unmodified; no width conversion.
- err is set by a watchdog timeout. It is cleared by err_clr. If set and clear coincide, set wins.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, gnt = 00, last = 1, err = 0, err_mst = 0, watchdog count = 0. All outputs are 0 immediately.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge k drives bus_stb during cycle k+1.
- Ack path is combinational: a zero-wait slave (ack in its first strobe cycle) completes in 2 cycles from request.
- Mandatory idle cycle between consecutive transactions: the back-to-back throughput of one master is 1 transaction per (slave latency + 1) cycles.
- Contention alternates strictly: with both stb always high, grants run m0, m1, m0, m1, each followed by one IDLE cycle.
- Reset mid-transaction: grant is dropped asynchronously and no ack reaches either master.
- A master deasserting stb before ack returns to IDLE at the next edge; no ack is generated.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering GNTx and increments each GNTx cycle while bus_ack = 0.
  - When the count reaches TIMEOUT-1 without bus_ack, the arbiter drives that cycle itself: bus_stb = 0, mx_ack = 1, mx_din = 0.
  - err is set, err_mst = x, and the FSM goes to IDLE.
  - A bus_ack arriving in the same cycle takes precedence: normal completion, no error.
- BUS_ARB_TIMEOUT_EN undefined: no counter. err and err_mst are tied to 0, err_clr is ignored, and a grant waits for bus_ack indefinitely.

## Test plan
- m0 read, slave acks 3 cycles after bus_stb with bus_din = 0x12345678 -> m0_din = 0x12345678 with m0_ack for 1 cycle; gnt = 01 for 4 cycles then 00; m1_ack stays 0.
- Both stb high from reset, zero-wait slave -> gnt sequence 01, 00, 10, 00, 01; bus_addr matches the granted master's addr each grant.
- m1 write addr 0x3FFFF0, dout 0xDEADBEEF during an m0 grant -> m1 held until m0 acked + 1 idle cycle; then bus_we = 1, bus_addr = 0x3FFFF0, bus_dout = 0xDEADBEEF.
- rst_n pulled low in the middle of a GNT1 transaction -> bus_stb, gnt and m1_ack go to 0 asynchronously; after release, m0 wins first contention.
- BUS_ARB_TIMEOUT_EN, TIMEOUT = 16, slave never acks on an m1 request -> m1_ack = 1 with m1_din = 0 on the 16th grant cycle; err = 1, err_mst = 1; err_clr pulse -> err = 0.
- BUS_ARB_TIMEOUT_EN, bus_ack arriving exactly on the timeout cycle -> normal completion with slave data, err remains 0.

Source files
------------

// File: rtl/bus_arb.sv
// bus_arb: round-robin two-master arbiter for the word-addressed system bus.
// Optional watchdog: define BUS_ARB_TIMEOUT_EN to terminate unacked grants.
module bus_arb #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [21:0] m0_addr,
  input  logic [31:0] m0_dout,
  output logic [31:0] m0_din,
  output logic        m0_ack,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [21:0] m1_addr,
  input  logic [31:0] m1_dout,
  output logic [31:0] m1_din,
  output logic        m1_ack,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [21:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic [1:0]  gnt,
  output logic        err,
  output logic        err_mst,
  input  logic        err_clr
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t state;
  state_t nxt;
  logic   last;
  logic   last_nxt;
  logic   to_hit;

  assign gnt = {state == GNT1, state == GNT0};

`ifdef BUS_ARB_TIMEOUT_EN
  logic [7:0] cnt;

  // A cycle with no ack in a grant reaches the limit.
  assign to_hit = (state != IDLE) && !bus_ack &&
                  (cnt == 8'(TIMEOUT - 1));

  // Watchdog count: cleared while idle, runs during a grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      cnt <= '0;
    end else if (!bus_ack) begin
      cnt <= cnt + 8'd1;
    end
  end

  // Sticky error flag; a new timeout beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_mst <= 1'b0;
    end else if (to_hit) begin
      err     <= 1'b1;
      err_mst <= (state == GNT1);
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end
`else
  logic unused_cfg;

  assign to_hit     = 1'b0;
  assign err        = 1'b0;
  assign err_mst    = 1'b0;
  assign unused_cfg = ^{err_clr, 8'(TIMEOUT)};
`endif

  // State and round-robin history registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= nxt;
      last  <= last_nxt;
    end
  end

  // Arbitration, bus mux and ack/data return.
  always_comb begin
    nxt      = state;
    last_nxt = last;
    bus_stb  = 1'b0;
    bus_we   = 1'b0;
    bus_addr = '0;
    bus_dout = '0;
    m0_ack   = 1'b0;
    m0_din   = '0;
    m1_ack   = 1'b0;
    m1_din   = '0;
    unique case (state)
      IDLE: begin
        if (m0_stb && m1_stb) begin
          nxt      = last ? GNT0 : GNT1;
          last_nxt = ~last;
        end else if (m0_stb) begin
          nxt = GNT0;
        end else if (m1_stb) begin
          nxt = GNT1;
        end
      end
      GNT0: begin
        bus_stb  = m0_stb;
        bus_we   = m0_we;
        bus_addr = m0_addr;
        bus_dout = m0_dout;
        m0_ack   = bus_ack;
        m0_din   = bus_din;
        if (bus_ack || !m0_stb) begin
          nxt = IDLE;
        end
        if (to_hit) begin
          bus_stb = 1'b0;
          m0_ack  = 1'b1;
          m0_din  = '0;
          nxt     = IDLE;
        end
      end
      GNT1: begin
        bus_stb  = m1_stb;
        bus_we   = m1_we;
        bus_addr = m1_addr;
        bus_dout = m1_dout;
        m1_ack   = bus_ack;
        m1_din   = bus_din;
        if (bus_ack || !m1_stb) begin
          nxt = IDLE;
        end
        if (to_hit) begin
          bus_stb = 1'b0;
          m1_ack  = 1'b1;
          m1_din  = '0;
          nxt     = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_arb.sv
// tb_bus_arb: directed self-checking bench for bus_arb.
// Watchdog cases are built when BUS_ARB_TIMEOUT_EN is defined.
module tb_bus_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_stb = 0, m0_we = 0;
  logic [21:0] m0_addr = '0;
  logic [31:0] m0_dout = '0;
  logic [31:0] m0_din;
  logic        m0_ack;
  logic        m1_stb = 0, m1_we = 0;
  logic [21:0] m1_addr = '0;
  logic [31:0] m1_dout = '0;
  logic [31:0] m1_din;
  logic        m1_ack;
  logic        bus_stb, bus_we;
  logic [21:0] bus_addr;
  logic [31:0] bus_dout;
  logic [31:0] bus_din = '0;
  logic        bus_ack;
  logic        man_ack = 0;
  logic        auto_ack = 0;
  logic [1:0]  gnt;
  logic        err, err_mst;
  logic        err_clr = 0;

  int n_chk = 0;
  int n_err = 0;

  assign bus_ack = auto_ack ? bus_stb : man_ack;

  always #10 clk = ~clk;

  bus_arb #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_dout(m0_dout), .m0_din(m0_din), .m0_ack(m0_ack),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_dout(m1_dout), .m1_din(m1_din), .m1_ack(m1_ack),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_dout(bus_dout), .bus_din(bus_din), .bus_ack(bus_ack),
    .gnt(gnt), .err(err), .err_mst(err_mst), .err_clr(err_clr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
  endtask

  initial begin
    do_reset();

    // reset state
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_stb", 32'(bus_stb), 0);
    chk("rst_addr", 32'(bus_addr), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_emst", 32'(err_mst), 0);

    // m0 read, slave acks on 4th strobe cycle
    m0_stb = 1; m0_we = 0; m0_addr = 22'h000100;
    settle();
    chk("rd_lat", 32'(gnt), 0);
    tick();
    chk("rd_g1", 32'(gnt), 1);
    chk("rd_stb", 32'(bus_stb), 1);
    chk("rd_addr", 32'(bus_addr), 32'h100);
    tick();
    chk("rd_g2", 32'(gnt), 1);
    tick();
    chk("rd_g3", 32'(gnt), 1);
    tick();
    man_ack = 1; bus_din = 32'h12345678;
    settle();
    chk("rd_g4", 32'(gnt), 1);
    chk("rd_ack", 32'(m0_ack), 1);
    chk("rd_din", m0_din, 32'h12345678);
    chk("rd_m1ack", 32'(m1_ack), 0);
    chk("rd_m1din", m1_din, 0);
    tick();
    m0_stb = 0; man_ack = 0;
    settle();
    chk("rd_idle", 32'(gnt), 0);
    chk("rd_ack0", 32'(m0_ack), 0);
    chk("rd_din0", m0_din, 0);

    // contention from reset, zero-wait slave
    do_reset();
    m0_addr = 22'h000AAA; m1_addr = 22'h000555;
    m0_stb = 1; m1_stb = 1; auto_ack = 1;
    tick();
    chk("rr_g1", 32'(gnt), 1);
    chk("rr_a1", 32'(bus_addr), 32'hAAA);
    chk("rr_k1", 32'(m0_ack), 1);
    tick();
    chk("rr_g2", 32'(gnt), 0);
    tick();
    chk("rr_g3", 32'(gnt), 2);
    chk("rr_a3", 32'(bus_addr), 32'h555);
    chk("rr_k3", 32'(m1_ack), 1);
    tick();
    chk("rr_g4", 32'(gnt), 0);
    tick();
    chk("rr_g5", 32'(gnt), 1);
    chk("rr_a5", 32'(bus_addr), 32'hAAA);
    m0_stb = 0; m1_stb = 0; auto_ack = 0;
    tick();
    tick();
    chk("rr_end", 32'(gnt), 0);

    // m1 write arrives during an m0 grant
    do_reset();
    m0_stb = 1; m0_we = 0; m0_addr = 22'h000010;
    tick();
    m1_stb = 1; m1_we = 1;
    m1_addr = 22'h3FFFF0; m1_dout = 32'hDEADBEEF;
    settle();
    chk("wr_g0", 32'(gnt), 1);
    chk("wr_we0", 32'(bus_we), 0);
    tick();
    chk("wr_hold", 32'(gnt), 1);
    man_ack = 1;
    settle();
    chk("wr_m0ack", 32'(m0_ack), 1);
    chk("wr_m1ack", 32'(m1_ack), 0);
    tick();
    m0_stb = 0; man_ack = 0;
    settle();
    chk("wr_gap", 32'(gnt), 0);
    chk("wr_gstb", 32'(bus_stb), 0);
    tick();
    chk("wr_g1", 32'(gnt), 2);
    chk("wr_we", 32'(bus_we), 1);
    chk("wr_addr", 32'(bus_addr), 32'h3FFFF0);
    chk("wr_dout", bus_dout, 32'hDEADBEEF);
    man_ack = 1;
    settle();
    chk("wr_ack", 32'(m1_ack), 1);
    tick();
    m1_stb = 0; m1_we = 0; man_ack = 0;
    settle();

    // reset in the middle of a GNT1 transaction
    m1_stb = 1;
    tick();
    chk("ar_g1", 32'(gnt), 2);
    #3;
    rst_n = 0; man_ack = 1;
    settle();
    chk("ar_stb", 32'(bus_stb), 0);
    chk("ar_gnt", 32'(gnt), 0);
    chk("ar_ack", 32'(m1_ack), 0);
    tick();
    rst_n = 1; man_ack = 0; m0_stb = 1;
    tick();
    chk("ar_first", 32'(gnt), 1);
    man_ack = 1;
    tick();
    m0_stb = 0; m1_stb = 0; man_ack = 0;
    tick();

    // master abort: no ack, back to idle
    m0_stb = 1;
    tick();
    chk("ab_g", 32'(gnt), 1);
    m0_stb = 0;
    settle();
    chk("ab_stb", 32'(bus_stb), 0);
    chk("ab_ack", 32'(m0_ack), 0);
    tick();
    chk("ab_idle", 32'(gnt), 0);

`ifdef BUS_ARB_TIMEOUT_EN
    // m1 request, slave never acks
    m1_stb = 1; bus_din = 32'h55AA55AA;
    tick();
    for (int i = 1; i < 16; i++) begin
      chk("wd_wait", 32'(m1_ack), 0);
      tick();
    end
    chk("wd_ack", 32'(m1_ack), 1);
    chk("wd_din", m1_din, 0);
    chk("wd_stb", 32'(bus_stb), 0);
    chk("wd_m0", 32'(m0_ack), 0);
    tick();
    m1_stb = 0;
    settle();
    chk("wd_err", 32'(err), 1);
    chk("wd_mst", 32'(err_mst), 1);
    chk("wd_idle", 32'(gnt), 0);
    err_clr = 1;
    tick();
    err_clr = 0;
    settle();
    chk("wd_clr", 32'(err), 0);

    // ack exactly on the timeout cycle wins
    m0_stb = 1;
    tick();
    for (int i = 1; i < 16; i++) begin
      tick();
    end
    man_ack = 1; bus_din = 32'hCAFEF00D;
    settle();
    chk("wd_rack", 32'(m0_ack), 1);
    chk("wd_rdin", m0_din, 32'hCAFEF00D);
    chk("wd_rstb", 32'(bus_stb), 1);
    tick();
    m0_stb = 0; man_ack = 0;
    settle();
    chk("wd_rerr", 32'(err), 0);
    chk("wd_ridle", 32'(gnt), 0);
`else
    // no watchdog: grant waits, err stays low
    m1_stb = 1;
    err_clr = 1;
    tick();
    err_clr = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
    end
    chk("nw_gnt", 32'(gnt), 2);
    chk("nw_ack", 32'(m1_ack), 0);
    chk("nw_err", 32'(err), 0);
    chk("nw_mst", 32'(err_mst), 0);
    man_ack = 1;
    settle();
    chk("nw_done", 32'(m1_ack), 1);
    tick();
    m1_stb = 0; man_ack = 0;
    settle();
    chk("nw_idle", 32'(gnt), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
